md_iteration_sequencer: RTL and testbench
=========================================

# md_iteration_sequencer

Sequential controller that owns the force-evaluation / motion-update iteration loop of the MD core, replacing the glue logic at the top level that collected per-PE reference-writeback flags and counted a fixed interconnect drain. It does four things:
- Tracks reference-particle writeback completion across all cells.
- Waits a runtime-programmable drain time for one or more ring interconnects.
- Issues single-cycle `iter_start` and `motion_update_start` pulses.
- Counts iterations and stops after a programmed count or on request.

It sits between the broadcast controller, the PE array, the rings, the force caches and `motion_update_control`.

## Interface
Parameters:
- `NUM_CELLS`, 64, number of PEs/cells.
- `NUM_RINGS`, 1, number of parallel force-writeback ring interconnects.
- `DRAIN_CNT_WIDTH`, 8, width of the drain counter and of `drain_cycles`.
- `ITER_CNT_WIDTH`, 16, width of the iteration counter and of `num_iters`.

Ports:
- `clk`  in  1  single clock; all logic is on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  run request pulse; honoured only in IDLE.
- `stop`  in  1  graceful stop request; honoured only when busy.
- `num_iters`  in  ITER_CNT_WIDTH  iterations to run; sampled on accepted `start`; 0 means run until `stop`.
- `drain_cycles`  in  DRAIN_CNT_WIDTH  ring drain wait; sampled on accepted `start`.
- `ref_wb_issued`  in  NUM_CELLS  per-PE pulse: reference force writeback issued.
- `goto_next_ref`  in  1  from the broadcast controller: advance to the next reference particle.
- `all_reading_done`  in  1  all PEs finished reading.
- `all_filter_buffer_empty`  in  1  all filter buffers are empty.
- `force_cache_input_buffer_empty`  in  1  all force-cache input buffers are empty.
- `ring_data_valid`  in  NUM_RINGS*NUM_CELLS  ring output write enables.
- `mu_done`  in  1  motion update finished (pulse).
- `iter_start`  out  1  registered pulse to the broadcast controller.
- `all_ref_wb_issued`  out  1  every PE has issued its reference writeback.
- `all_force_wr_issued`  out  1  force writeback is fully quiesced.
- `motion_update_start`  out  1  registered pulse to `motion_update_control`.
- `iter_count`  out  ITER_CNT_WIDTH  number of completed iterations.
- `busy`  out  1  high whenever the main FSM is not in IDLE.
- `run_done`  out  1  pulse when a run finishes.

Reset values: every output is 0.

## Operation
Main FSM states: IDLE, FORCE, MU.
- **IDLE.** On `start`:
  - Latch `num_iters` and `drain_cycles`.
  - Clear `iter_count` and `stop_pending`.
  - Go to FORCE and pulse `iter_start`.
- **FORCE.** When `all_reading_done & all_force_wr_issued` is true, pulse `motion_update_start` and go to MU. The pulse fires exactly once per iteration.
- **MU.** On `mu_done`, increment `iter_count` (wraps modulo 2^ITER_CNT_WIDTH). Then:
  - If `stop_pending`, or (`num_iters != 0` and the new count equals `num_iters`): go to IDLE and pulse `run_done`.
  - Otherwise: go to FORCE and pulse `iter_start`.
- **stop.** `stop` while busy sets `stop_pending`; the current iteration always completes. `stop` in IDLE is ignored, including when it coincides with `start`.
- **start while busy** is ignored.

Reference-writeback tracker states: COLLECT, DRAIN, HOLD. The tracker is active only in FORCE and is forced to COLLECT with a cleared vector in all other main states.
- **COLLECT.** Accumulate `ref_wb_issued` into a sticky vector.
  - When (vector | `ref_wb_issued`) is all ones, go to DRAIN (counter = 0). Same-cycle pulses count toward the transition.
  - If `drain_cycles == 0`, go directly to HOLD instead.
- **DRAIN.** Increment the counter each cycle. On reaching `drain_cycles`, go to HOLD.
- **HOLD.** Stay in HOLD until `goto_next_ref`.
- **goto_next_ref** in DRAIN or HOLD returns the tracker to COLLECT and clears the vector and counter. It takes priority over the drain-complete transition. In COLLECT it is ignored.
- `all_ref_wb_issued` = tracker state is not COLLECT.
- `interconnect_empty` = tracker state is HOLD.
- `all_force_wr_issued` = `(ring_data_valid == 0) & force_cache_input_buffer_empty & all_filter_buffer_empty & all_ref_wb_issued & interconnect_empty`. This output is combinational from registered state and the inputs.

## Timing
- `start` at cycle T: `busy` and `iter_start` are high at T+1, and `iter_start` is low again at T+2.
- FORCE exit condition true at cycle T: `motion_update_start` is high for cycle T+1 only, and the state is MU at T+1.
- `mu_done` at cycle T:
  - `iter_count` is updated at T+1.
  - Either `iter_start` or `run_done` is high at T+1.
  - When finishing, `busy` is low at T+1.
- Drain timing: with the vector complete at cycle T and `drain_cycles = D > 0`, `interconnect_empty` rises at T+1+D.
- Reset asserted mid-run: immediate return to IDLE with all outputs 0 and no pending pulses.

## Configuration
- `MD_ITER_SEQ_PERF_EN` defined:
  - Adds output `perf_drain_cycles` (32 bits), counting cycles spent in DRAIN.
  - Adds output `perf_stall_cycles` (32 bits), counting cycles in HOLD with `all_force_wr_issued` low.
  - Both counters clear on an accepted `start` and saturate at all ones.
- Macro undefined: the ports and counters do not exist. Behaviour is otherwise identical.

## Structure
- Add to `md_pkg`:
  - `iter_seq_state_t` enum (IDLE, FORCE, MU).
  - `ref_trk_state_t` enum (COLLECT, DRAIN, HOLD).
- Sub-module `ref_wb_tracker`: sticky vector, drain counter and tracker FSM. Outputs are `all_ref_wb_issued` and `interconnect_empty`.

## Test plan
- `NUM_CELLS=4`, `num_iters=2`, `drain_cycles=3`:
  - Two full iterations occur.
  - `iter_start` pulses twice, `motion_update_start` pulses twice.
  - `run_done` pulses once and `iter_count=2`.
- All four `ref_wb_issued` bits arrive in the same cycle T: `all_ref_wb_issued` at T+1, `interconnect_empty` at T+4.
- `goto_next_ref` during DRAIN at counter 1: tracker returns to COLLECT, the vector clears and `interconnect_empty` never rises.
- `drain_cycles=0`: HOLD is entered the cycle after the vector completes. `ring_data_valid` nonzero holds `all_force_wr_issued` low until it clears.
- `num_iters=0` with `stop` asserted in FORCE of iteration 5: the iteration completes, then `run_done` with `iter_count=5`.
- Reset asserted while in MU: all outputs are 0 next edge. A subsequent `start` with `num_iters=1` runs exactly one iteration.

Source files
------------

// File: rtl/md_pkg.sv
// Shared types for the MD core iteration sequencer and its reference-writeback tracker.
package md_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FORCE = 2'd1,
        MU    = 2'd2
    } iter_seq_state_t;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        DRAIN   = 2'd1,
        HOLD    = 2'd2
    } ref_trk_state_t;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : (v + 32'd1);
    endfunction

endpackage

// File: rtl/ref_wb_tracker.sv
// Collects per-PE reference writeback flags, then waits the programmed ring drain
// time before declaring the interconnect empty; held until goto_next_ref.
module ref_wb_tracker
    import md_pkg::*;
#(
    parameter int NUM_CELLS       = 64,
    parameter int DRAIN_CNT_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       active,
    input  logic [DRAIN_CNT_WIDTH-1:0] drain_cycles,
    input  logic [NUM_CELLS-1:0]       ref_wb_issued,
    input  logic                       goto_next_ref,
    output logic                       all_ref_wb_issued,
    output logic                       interconnect_empty
);

    localparam logic [DRAIN_CNT_WIDTH-1:0] CNT_ZERO = {DRAIN_CNT_WIDTH{1'b0}};
    localparam logic [DRAIN_CNT_WIDTH-1:0] CNT_ONE  = {{(DRAIN_CNT_WIDTH-1){1'b0}}, 1'b1};

    ref_trk_state_t             state_q, state_d;
    logic [NUM_CELLS-1:0]       vec_q, vec_d;
    logic [DRAIN_CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [DRAIN_CNT_WIDTH-1:0] cnt_inc_s;

    assign cnt_inc_s = cnt_q + CNT_ONE;

    // Tracker next-state: goto_next_ref outranks drain completion.
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        if (!active) begin
            state_d = COLLECT;
            vec_d   = {NUM_CELLS{1'b0}};
            cnt_d   = CNT_ZERO;
        end else begin
            case (state_q)
                COLLECT: begin
                    vec_d = vec_q | ref_wb_issued;
                    if (&vec_d) begin
                        cnt_d   = CNT_ZERO;
                        state_d = (drain_cycles == CNT_ZERO) ? HOLD : DRAIN;
                    end else begin
                        state_d = COLLECT;
                    end
                end
                DRAIN: begin
                    if (goto_next_ref) begin
                        state_d = COLLECT;
                        vec_d   = {NUM_CELLS{1'b0}};
                        cnt_d   = CNT_ZERO;
                    end else if (cnt_inc_s == drain_cycles) begin
                        state_d = HOLD;
                        cnt_d   = cnt_inc_s;
                    end else begin
                        cnt_d   = cnt_inc_s;
                    end
                end
                HOLD: begin
                    if (goto_next_ref) begin
                        state_d = COLLECT;
                        vec_d   = {NUM_CELLS{1'b0}};
                        cnt_d   = CNT_ZERO;
                    end else begin
                        state_d = HOLD;
                    end
                end
                default: begin
                    state_d = COLLECT;
                    vec_d   = {NUM_CELLS{1'b0}};
                    cnt_d   = CNT_ZERO;
                end
            endcase
        end
    end

    // Tracker state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= COLLECT;
            vec_q   <= {NUM_CELLS{1'b0}};
            cnt_q   <= CNT_ZERO;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
        end
    end

    assign all_ref_wb_issued  = (state_q != COLLECT);
    assign interconnect_empty = (state_q == HOLD);

endmodule

// File: rtl/md_iteration_sequencer.sv
// Force-evaluation / motion-update iteration loop controller for the MD core.
// Build option: MD_ITER_SEQ_PERF_EN adds saturating DRAIN and HOLD-stall cycle counters.
module md_iteration_sequencer
    import md_pkg::*;
#(
    parameter int NUM_CELLS       = 64,
    parameter int NUM_RINGS       = 1,
    parameter int DRAIN_CNT_WIDTH = 8,
    parameter int ITER_CNT_WIDTH  = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           stop,
    input  logic [ITER_CNT_WIDTH-1:0]      num_iters,
    input  logic [DRAIN_CNT_WIDTH-1:0]     drain_cycles,
    input  logic [NUM_CELLS-1:0]           ref_wb_issued,
    input  logic                           goto_next_ref,
    input  logic                           all_reading_done,
    input  logic                           all_filter_buffer_empty,
    input  logic                           force_cache_input_buffer_empty,
    input  logic [NUM_RINGS*NUM_CELLS-1:0] ring_data_valid,
    input  logic                           mu_done,
`ifdef MD_ITER_SEQ_PERF_EN
    output logic [31:0]                    perf_drain_cycles,
    output logic [31:0]                    perf_stall_cycles,
`endif
    output logic                           iter_start,
    output logic                           all_ref_wb_issued,
    output logic                           all_force_wr_issued,
    output logic                           motion_update_start,
    output logic [ITER_CNT_WIDTH-1:0]      iter_count,
    output logic                           busy,
    output logic                           run_done
);

    localparam logic [ITER_CNT_WIDTH-1:0] ITER_ZERO = {ITER_CNT_WIDTH{1'b0}};
    localparam logic [ITER_CNT_WIDTH-1:0] ITER_ONE  = {{(ITER_CNT_WIDTH-1){1'b0}}, 1'b1};

    iter_seq_state_t               state_q, state_d;
    logic [ITER_CNT_WIDTH-1:0]     iter_count_q, iter_count_d;
    logic [ITER_CNT_WIDTH-1:0]     num_iters_q, num_iters_d;
    logic [DRAIN_CNT_WIDTH-1:0]    drain_q, drain_d;
    logic                          stop_pend_q, stop_pend_d;
    logic                          iter_start_q, iter_start_d;
    logic                          mu_start_q, mu_start_d;
    logic                          run_done_q, run_done_d;
    logic [ITER_CNT_WIDTH-1:0]     count_inc_s;
    logic                          stop_now_s;
    logic                          interconnect_empty;

    ref_wb_tracker #(
        .NUM_CELLS       (NUM_CELLS),
        .DRAIN_CNT_WIDTH (DRAIN_CNT_WIDTH)
    ) u_ref_wb_tracker (
        .clk                (clk),
        .rst                (rst),
        .active             (state_q == FORCE),
        .drain_cycles       (drain_q),
        .ref_wb_issued      (ref_wb_issued),
        .goto_next_ref      (goto_next_ref),
        .all_ref_wb_issued  (all_ref_wb_issued),
        .interconnect_empty (interconnect_empty)
    );

    assign all_force_wr_issued = (ring_data_valid == {(NUM_RINGS*NUM_CELLS){1'b0}})
                               & force_cache_input_buffer_empty & all_filter_buffer_empty
                               & all_ref_wb_issued & interconnect_empty;

    assign count_inc_s = iter_count_q + ITER_ONE;
    assign stop_now_s  = stop_pend_q | stop;

    // Main FSM next-state; a stop seen alongside mu_done ends the run at that iteration.
    always_comb begin
        state_d      = state_q;
        iter_count_d = iter_count_q;
        num_iters_d  = num_iters_q;
        drain_d      = drain_q;
        stop_pend_d  = stop_pend_q;
        iter_start_d = 1'b0;
        mu_start_d   = 1'b0;
        run_done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    num_iters_d  = num_iters;
                    drain_d      = drain_cycles;
                    iter_count_d = ITER_ZERO;
                    stop_pend_d  = 1'b0;
                    iter_start_d = 1'b1;
                    state_d      = FORCE;
                end else begin
                    state_d      = IDLE;
                end
            end
            FORCE: begin
                stop_pend_d = stop_now_s;
                if (all_reading_done & all_force_wr_issued) begin
                    mu_start_d = 1'b1;
                    state_d    = MU;
                end else begin
                    state_d    = FORCE;
                end
            end
            MU: begin
                stop_pend_d = stop_now_s;
                if (mu_done) begin
                    iter_count_d = count_inc_s;
                    if (stop_now_s || ((num_iters_q != ITER_ZERO) && (count_inc_s == num_iters_q))) begin
                        run_done_d   = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        iter_start_d = 1'b1;
                        state_d      = FORCE;
                    end
                end else begin
                    state_d = MU;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Main FSM and pulse registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            iter_count_q <= ITER_ZERO;
            num_iters_q  <= ITER_ZERO;
            drain_q      <= {DRAIN_CNT_WIDTH{1'b0}};
            stop_pend_q  <= 1'b0;
            iter_start_q <= 1'b0;
            mu_start_q   <= 1'b0;
            run_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            iter_count_q <= iter_count_d;
            num_iters_q  <= num_iters_d;
            drain_q      <= drain_d;
            stop_pend_q  <= stop_pend_d;
            iter_start_q <= iter_start_d;
            mu_start_q   <= mu_start_d;
            run_done_q   <= run_done_d;
        end
    end

    assign iter_start          = iter_start_q;
    assign motion_update_start = mu_start_q;
    assign run_done            = run_done_q;
    assign iter_count          = iter_count_q;
    assign busy                = (state_q != IDLE);

`ifdef MD_ITER_SEQ_PERF_EN
    logic [31:0] perf_drain_q, perf_drain_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    // DRAIN is the only tracker state that reports writeback done without an empty ring.
    always_comb begin
        perf_drain_d = perf_drain_q;
        perf_stall_d = perf_stall_q;
        if ((state_q == IDLE) && start) begin
            perf_drain_d = 32'd0;
            perf_stall_d = 32'd0;
        end else begin
            if (all_ref_wb_issued & ~interconnect_empty) begin
                perf_drain_d = sat_inc32(perf_drain_q);
            end else begin
                perf_drain_d = perf_drain_q;
            end
            if (interconnect_empty & ~all_force_wr_issued) begin
                perf_stall_d = sat_inc32(perf_stall_q);
            end else begin
                perf_stall_d = perf_stall_q;
            end
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_drain_q <= 32'd0;
            perf_stall_q <= 32'd0;
        end else begin
            perf_drain_q <= perf_drain_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_drain_cycles = perf_drain_q;
    assign perf_stall_cycles = perf_stall_q;
`endif

endmodule

// File: tb/tb_md_iteration_sequencer.sv
// Self-checking bench: run table, directed corner sequences and random stimulus vs. a behavioural model.
module tb_md_iteration_sequencer;

    localparam int NC = 4;
    localparam int NR = 1;
    localparam int DW = 8;
    localparam int IW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start, stop, goto_next_ref, all_reading_done;
    logic          all_filter_buffer_empty, force_cache_input_buffer_empty, mu_done;
    logic [IW-1:0] num_iters;
    logic [DW-1:0] drain_cycles;
    logic [NC-1:0] ref_wb_issued;
    logic [NR*NC-1:0] ring_data_valid;
    logic          iter_start, all_ref_wb_issued, all_force_wr_issued;
    logic          motion_update_start, busy, run_done;
    logic [IW-1:0] iter_count;
`ifdef MD_ITER_SEQ_PERF_EN
    logic [31:0]   perf_drain_cycles, perf_stall_cycles;
`endif

    always #5 clk = ~clk;

    md_iteration_sequencer #(
        .NUM_CELLS(NC), .NUM_RINGS(NR), .DRAIN_CNT_WIDTH(DW), .ITER_CNT_WIDTH(IW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .num_iters(num_iters), .drain_cycles(drain_cycles),
        .ref_wb_issued(ref_wb_issued), .goto_next_ref(goto_next_ref),
        .all_reading_done(all_reading_done),
        .all_filter_buffer_empty(all_filter_buffer_empty),
        .force_cache_input_buffer_empty(force_cache_input_buffer_empty),
        .ring_data_valid(ring_data_valid), .mu_done(mu_done),
`ifdef MD_ITER_SEQ_PERF_EN
        .perf_drain_cycles(perf_drain_cycles), .perf_stall_cycles(perf_stall_cycles),
`endif
        .iter_start(iter_start), .all_ref_wb_issued(all_ref_wb_issued),
        .all_force_wr_issued(all_force_wr_issued),
        .motion_update_start(motion_update_start), .iter_count(iter_count),
        .busy(busy), .run_done(run_done)
    );

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model: run phase, counts, and the absolute cycle the ring is known empty.
    int   m_phase;      // 0 idle, 1 force, 2 motion update
    int   m_count, m_target, m_drain;
    bit   m_pend, m_is, m_ms, m_rd;
    bit   m_complete;
    logic [NC-1:0] m_seen;
    int   m_cyc = 0;
    int   m_hold_at = 0;

    task automatic model_reset();
        m_phase = 0; m_count = 0; m_target = 0; m_drain = 0;
        m_pend = 0; m_is = 0; m_ms = 0; m_rd = 0;
        m_complete = 0; m_seen = '0;
    endtask

    function automatic bit m_afw();
        return (ring_data_valid == 0) && force_cache_input_buffer_empty &&
               all_filter_buffer_empty && m_complete && (m_cyc >= m_hold_at);
    endfunction

    task automatic step();
        logic s_start, s_stop, s_goto, s_ard, s_mu;
        logic [NC-1:0] s_ref;
        int  s_num, s_drain, ph;
        bit  afw_pre;
        logic [21:0] exp_v, act_v;
        s_start = start; s_stop = stop; s_goto = goto_next_ref; s_ard = all_reading_done;
        s_mu = mu_done; s_ref = ref_wb_issued; s_num = int'(num_iters); s_drain = int'(drain_cycles);
        afw_pre = m_afw();
        ph = m_phase;
        @(posedge clk);
        #1;
        if (ph != 1) begin
            m_complete = 0; m_seen = '0;
        end else if (!m_complete) begin
            m_seen = m_seen | s_ref;
            if (&m_seen) begin
                m_complete = 1;
                m_hold_at = m_cyc + 1 + m_drain;
            end
        end else if (s_goto) begin
            m_complete = 0; m_seen = '0;
        end
        m_is = 0; m_ms = 0; m_rd = 0;
        if (ph == 0) begin
            if (s_start) begin
                m_target = s_num; m_drain = s_drain; m_count = 0; m_pend = 0;
                m_phase = 1; m_is = 1;
            end
        end else if (ph == 1) begin
            if (s_stop) m_pend = 1;
            if (afw_pre && s_ard) begin m_phase = 2; m_ms = 1; end
        end else begin
            if (s_stop) m_pend = 1;
            if (s_mu) begin
                m_count = (m_count + 1) % 65536;
                if (m_pend || (m_target != 0 && m_count == m_target)) begin
                    m_phase = 0; m_rd = 1;
                end else begin
                    m_phase = 1; m_is = 1;
                end
            end
        end
        m_cyc++;
        exp_v = {m_is, m_ms, m_rd, (m_phase != 0), m_complete, m_afw(), m_count[15:0]};
        act_v = {iter_start, motion_update_start, run_done, busy, all_ref_wb_issued,
                 all_force_wr_issued, iter_count};
        check($sformatf("model_cycle_%0d", m_cyc), {42'd0, act_v}, {42'd0, exp_v});
    endtask

    task automatic quiet_inputs();
        start = 0; stop = 0; goto_next_ref = 0; all_reading_done = 1;
        all_filter_buffer_empty = 1; force_cache_input_buffer_empty = 1;
        mu_done = 0; ref_wb_issued = '0; ring_data_valid = '0;
        num_iters = '0; drain_cycles = '0;
    endtask

    // Cooperative environment: writebacks immediate, mu_done answers motion_update_start.
    task automatic drive_loop(input int stop_at, input int budget,
                              output int c_is, output int c_ms, output int c_rd);
        bit done = 0;
        c_is = 0; c_ms = 0; c_rd = 0;
        all_reading_done = 1; all_filter_buffer_empty = 1; force_cache_input_buffer_empty = 1;
        ring_data_valid = '0; goto_next_ref = 0; start = 0; ref_wb_issued = '1;
        for (int k = 0; k < budget && !done; k++) begin
            if (iter_start) c_is++;
            if (motion_update_start) c_ms++;
            if (run_done) begin c_rd++; done = 1; end
            if (!done) begin
                mu_done = motion_update_start;
                stop = iter_start && (c_is == stop_at);
                step();
            end
        end
        mu_done = 0; stop = 0; ref_wb_issued = '0;
        check("run_completed_within_budget", {63'd0, done}, 64'd1);
    endtask

    typedef struct {
        int num_iters;
        int drain;
        int stop_at;
        int exp_is;
        int exp_ms;
        int exp_rd;
        int exp_cnt;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int c_is, c_ms, c_rd;
        int k;
        tbl[0] = '{2, 3, 0, 2, 2, 1, 2};
        tbl[1] = '{0, 1, 5, 5, 5, 1, 5};
        tbl[2] = '{1, 0, 0, 1, 1, 1, 1};
        tbl[3] = '{3, 2, 0, 3, 3, 1, 3};
        tbl[4] = '{0, 0, 1, 1, 1, 1, 1};

        rst = 0;
        quiet_inputs();
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        check("reset_outputs", {57'd0, iter_start, motion_update_start, run_done, busy,
              all_ref_wb_issued, all_force_wr_issued, (iter_count != 0)}, 64'd0);
        rst = 1;

        for (int i = 0; i < 5; i++) begin
            quiet_inputs();
            start = 1; num_iters = IW'(tbl[i].num_iters); drain_cycles = DW'(tbl[i].drain);
            step();
            start = 0;
            drive_loop(tbl[i].stop_at, 600, c_is, c_ms, c_rd);
            check($sformatf("tbl%0d_iter_starts", i), c_is, tbl[i].exp_is);
            check($sformatf("tbl%0d_mu_starts", i), c_ms, tbl[i].exp_ms);
            check($sformatf("tbl%0d_run_done", i), c_rd, tbl[i].exp_rd);
            check($sformatf("tbl%0d_iter_count", i), iter_count, tbl[i].exp_cnt);
            step();
        end

        // All four writebacks in one cycle T with drain 3.
        quiet_inputs();
        all_reading_done = 0; start = 1; num_iters = 16'd1; drain_cycles = 8'd3;
        step(); start = 0;
        step();
        ref_wb_issued = 4'hF; step(); ref_wb_issued = 4'h0;
        check("same_cycle_all_ref_t1", all_ref_wb_issued, 1);
        check("same_cycle_afw_t1", all_force_wr_issued, 0);
        step(); check("same_cycle_afw_t2", all_force_wr_issued, 0);
        step(); check("same_cycle_afw_t3", all_force_wr_issued, 0);
        step(); check("same_cycle_afw_t4", all_force_wr_issued, 1);
        drive_loop(0, 100, c_is, c_ms, c_rd);
        check("same_cycle_run_done", c_rd, 1);
        step();

        // goto_next_ref while draining at counter 1.
        quiet_inputs();
        all_reading_done = 0; start = 1; num_iters = 16'd1; drain_cycles = 8'd3;
        step(); start = 0;
        ref_wb_issued = 4'hF; step(); ref_wb_issued = 4'h0;
        check("goto_drain_all_ref_t1", all_ref_wb_issued, 1);
        step();
        goto_next_ref = 1; step(); goto_next_ref = 0;
        check("goto_drain_back_to_collect", all_ref_wb_issued, 0);
        k = 0;
        for (int j = 0; j < 6; j++) begin
            step();
            if (all_force_wr_issued !== 1'b0 || all_ref_wb_issued !== 1'b0) k++;
        end
        check("goto_drain_never_empty", k, 0);
        drive_loop(0, 100, c_is, c_ms, c_rd);
        check("goto_drain_run_done", c_rd, 1);
        step();

        // Zero drain: HOLD right after completion, ring traffic still blocks.
        quiet_inputs();
        ring_data_valid = 4'b0010; start = 1; num_iters = 16'd1; drain_cycles = 8'd0;
        step(); start = 0;
        ref_wb_issued = 4'hF; step(); ref_wb_issued = 4'h0;
        check("zero_drain_all_ref_t1", all_ref_wb_issued, 1);
        check("zero_drain_ring_blocks", all_force_wr_issued, 0);
        ring_data_valid = '0; #1;
        check("zero_drain_hold_at_t1", all_force_wr_issued, 1);
        ring_data_valid = 4'b1000; step();
        check("zero_drain_no_mu_start", motion_update_start, 0);
        ring_data_valid = '0; step();
        check("zero_drain_mu_start", motion_update_start, 1);
        drive_loop(0, 100, c_is, c_ms, c_rd);
        check("zero_drain_run_done", c_rd, 1);
        step();

        // Reset while in MU, then a single-iteration run.
        quiet_inputs();
        start = 1; num_iters = 16'd3; drain_cycles = 8'd0; ref_wb_issued = 4'hF;
        step(); start = 0;
        k = 0;
        while (!motion_update_start && k < 50) begin step(); k++; end
        check("reached_mu_before_reset", motion_update_start, 1);
        #2 rst = 0; #1;
        check("reset_mid_mu_immediate", {57'd0, iter_start, motion_update_start, run_done, busy,
              all_ref_wb_issued, all_force_wr_issued, (iter_count != 0)}, 64'd0);
        model_reset();
        @(posedge clk); #1;
        check("reset_mid_mu_next_edge", {57'd0, iter_start, motion_update_start, run_done, busy,
              all_ref_wb_issued, all_force_wr_issued, (iter_count != 0)}, 64'd0);
        rst = 1;
        quiet_inputs();
        start = 1; num_iters = 16'd1; drain_cycles = 8'd2;
        step(); start = 0;
        drive_loop(0, 100, c_is, c_ms, c_rd);
        check("after_reset_iter_starts", c_is, 1);
        check("after_reset_mu_starts", c_ms, 1);
        check("after_reset_iter_count", iter_count, 1);
        step();

        // Randomized traffic against the model.
        for (int r = 0; r < 3000; r++) begin
            start = ($urandom % 8 == 0);
            stop = ($urandom % 40 == 0);
            num_iters = IW'($urandom % 4);
            drain_cycles = DW'($urandom % 5);
            for (int b = 0; b < NC; b++) ref_wb_issued[b] = ($urandom % 3 == 0);
            goto_next_ref = ($urandom % 10 == 0);
            all_reading_done = ($urandom % 4 != 0);
            all_filter_buffer_empty = ($urandom % 8 != 0);
            force_cache_input_buffer_empty = ($urandom % 8 != 0);
            ring_data_valid = ($urandom % 6 == 0) ? NC'($urandom) : '0;
            mu_done = ($urandom % 3 == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
